alu_seq: RTL

Parametrised successor to the 32-bit registered ALU. It keeps the existing 4-bit operation codes and the zero/cout/overflow flags, and adds:
- configurable width;
- barrel shifts;
- an iterative multi-cycle unsigned multiply;
- valid/ready handshakes on both the operand side and the result side.

It sits between the decode/issue stage and writeback. It accepts one operation at a time and holds each result until the consumer takes it.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_mul.sv | 72 +++++++
 rtl/alu_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - 4-bit opcodes. These are the same codes the older 32-bit ALU uses.
//   - the two-state control FSM enum used by alu_seq.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] OR  = 4'b0001;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] NOR = 4'b1100;
    localparam logic [3:0] SLT = 4'b0111;
    localparam logic [3:0] SLL = 4'b1000;
    localparam logic [3:0] SRL = 4'b1001;
    localparam logic [3:0] SRA = 4'b1010;
    localparam logic [3:0] MUL = 4'b0011;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// ---------------------------------------------------------------------------
// alu_seq_mul
// Iterative unsigned radix-2 shift-add multiplier. It uses a 2*WIDTH
// accumulator.
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   start       latch a/b, clear the accumulator and load the counter with WIDTH
//   a, b        multiplicand and multiplier, sampled on start
//   done        high during the last iteration cycle
//   product     full 2*WIDTH product; valid while done is high
// Each cycle with a non-zero counter performs one iteration. `product` is the
// accumulator value after the current iteration. This lets the parent capture
// the final product on the same edge where the counter reaches zero.
// ---------------------------------------------------------------------------
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_sum;

    // The accumulator value after this cycle's iteration.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product = acc_sum;
    assign done    = (cnt_q == CW'(1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Parametrised registered ALU with valid/ready handshakes on the operand side
// and on the result side. Single-cycle ops are: logic ops, ADD, SUB, SLT and
// the barrel shifts. MUL is iterative and takes WIDTH cycles.
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   src1, src2          operands; the shift amount is src2[SHW-1:0]
//   alu_control         4-bit opcode (see alu_pkg)
//   out_valid/out_ready result handshake
//   result, zero, cout, overflow   registered result and flags
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    state_e state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic               mul_start, mul_done, load;
    logic [2*WIDTH-1:0] mul_product;

    // ---------------- single-cycle datapath ----------------
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] add_low;
    logic             add_cout, add_ovf, slt_bit;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_result;
    logic             sc_cout, sc_ovf;

    // SLT shares the subtractor. That makes it a true signed compare.
    assign sub_mode = (alu_control == SUB) || (alu_control == SLT);
    assign b_eff    = sub_mode ? ~src2 : src2;
    assign add_full = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    assign add_cout = add_full[WIDTH];
    // Bit WIDTH-1 of the low-order sum is the carry into the MSB.
    assign add_low  = {1'b0, src1[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                      + {{(WIDTH-1){1'b0}}, sub_mode};
    assign add_ovf  = add_low[WIDTH-1] ^ add_cout;
    assign slt_bit  = add_full[WIDTH-1] ^ add_ovf;
    assign shamt    = src2[SHW-1:0];

    always_comb begin
        sc_result = '0;
        sc_cout   = 1'b0;
        sc_ovf    = 1'b0;
        case (alu_control)
            AND: sc_result = src1 & src2;
            OR:  sc_result = src1 | src2;
            NOR: sc_result = ~(src1 | src2);
            ADD, SUB: begin
                sc_result = add_full[WIDTH-1:0];
                sc_cout   = add_cout;
                sc_ovf    = add_ovf;
            end
            SLT: sc_result = {{(WIDTH-1){1'b0}}, slt_bit};
            SLL: sc_result = src1 << shamt;
            SRL: sc_result = src1 >> shamt;
            SRA: sc_result = $unsigned($signed(src1) >>> shamt);
            default: sc_result = '0;
        endcase
    end

    // ---------------- multiplier ----------------
    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (src1),
        .b       (src2),
        .done    (mul_done),
        .product (mul_product)
    );

    // ---------------- control FSM ----------------
    // MUL is accepted only when the output slot is free or draining. So a
    // multiply that completes never overwrites an unconsumed result.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (alu_control == MUL) begin
                        mul_start = 1'b1;
                        state_d   = MULT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            MULT: begin
                if (mul_done) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output register ----------------
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (load) begin
            out_valid_d = 1'b1;
            if (state_q == MULT) begin
                result_d = mul_product[WIDTH-1:0];
                cout_d   = 1'b0;
                ovf_d    = |mul_product[2*WIDTH-1:WIDTH];
            end else begin
                result_d = sc_result;
                cout_d   = sc_cout;
                ovf_d    = sc_ovf;
            end
            zero_d = (result_d == '0);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule
